// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, ALU opcode encodings and a small sizing helper for the ALU
// reservation station.
package alu_reservation_station_pkg;

    localparam int ROB_TAG_W = 5;
    localparam int ALU_OP_W  = 5;
    localparam int DATA_W    = 32;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_LUI  = 5'd10,
        ALU_AUIPC = 5'd11
    } alu_op_e;

    // Index width that stays at least one bit even for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rs_priority_pick.sv
// Lowest-index finder: reports whether any request bit is set and the index
// of the lowest one.
module rs_priority_pick
    import alu_reservation_station_pkg::*;
#(
    parameter int N = 8,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    output logic          found,
    output logic [IW-1:0] idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // it unassigned, which would otherwise infer a latch.
        found = |req;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// Tomasulo reservation station for the ALU: buffers issued instructions, snoops
// the CDB for pending operands and dispatches one ready entry per cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE = 8,
    parameter int ROB_W   = ROB_TAG_W,
    parameter int OP_W    = ALU_OP_W
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              _clear,
    input  logic              _issue_valid,
    input  logic [ROB_W-1:0]  _issue_rob_id,
    input  logic [OP_W-1:0]   _issue_op,
    input  logic              _issue_qj_valid,
    input  logic [ROB_W-1:0]  _issue_qj,
    input  logic [31:0]       _issue_vj,
    input  logic              _issue_qk_valid,
    input  logic [ROB_W-1:0]  _issue_qk,
    input  logic [31:0]       _issue_vk,
    output logic              _rs_full,
    input  logic              _cdb_ready,
    input  logic [ROB_W-1:0]  _cdb_rob_id,
    input  logic [31:0]       _cdb_value,
    input  logic              _alu_full,
    output logic              _alu_ready,
    output logic [ROB_W-1:0]  _alu_rob_id,
    output logic [OP_W-1:0]   _alu_op,
    output logic [31:0]       _alu_vj,
    output logic [31:0]       _alu_vk
);

    localparam int IW = idx_width(RS_SIZE);

    logic [RS_SIZE-1:0] busy;
    logic [RS_SIZE-1:0] qj_valid;
    logic [RS_SIZE-1:0] qk_valid;
    logic [OP_W-1:0]    ent_op  [RS_SIZE];
    logic [ROB_W-1:0]   ent_rob [RS_SIZE];
    logic [ROB_W-1:0]   ent_qj  [RS_SIZE];
    logic [ROB_W-1:0]   ent_qk  [RS_SIZE];
    logic [31:0]        ent_vj  [RS_SIZE];
    logic [31:0]        ent_vk  [RS_SIZE];

    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_SIZE-1:0] free_vec;
    logic               ready_found;
    logic               free_found;
    logic [IW-1:0]      ready_idx;
    logic [IW-1:0]      free_idx;
    logic               issue_ok;
    logic               dispatch_ok;
    logic               fwd_j;
    logic               fwd_k;

    assign _rs_full  = &busy;
    assign ready_vec = busy & ~qj_valid & ~qk_valid;
    assign free_vec  = ~busy;

    rs_priority_pick #(.N(RS_SIZE)) u_free_pick (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_priority_pick #(.N(RS_SIZE)) u_ready_pick (
        .req   (ready_vec),
        .found (ready_found),
        .idx   (ready_idx)
    );

    assign issue_ok    = _issue_valid && free_found;
    assign dispatch_ok = !_alu_full && ready_found;

    // A producer completing in the issue cycle would otherwise be missed forever.
    assign fwd_j = _issue_qj_valid && _cdb_ready && (_issue_qj == _cdb_rob_id);
    assign fwd_k = _issue_qk_valid && _cdb_ready && (_issue_qk == _cdb_rob_id);

    // Occupancy and the dispatch port; clear outranks everything but reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        // NOTE: state is updated with non-blocking assignments so every read in
        // this block sees the pre-edge value regardless of statement order.
        if (rst_in) begin
            busy        <= '0;
            _alu_ready  <= 1'b0;
            _alu_rob_id <= '0;
            _alu_op     <= '0;
            _alu_vj     <= '0;
            _alu_vk     <= '0;
        end else if (_clear) begin
            busy       <= '0;
            _alu_ready <= 1'b0;
        end else if (!rdy_in) begin
            _alu_ready <= 1'b0;
        end else begin
            _alu_ready <= dispatch_ok;
            if (dispatch_ok) begin
                busy[ready_idx] <= 1'b0;
                _alu_rob_id     <= ent_rob[ready_idx];
                _alu_op         <= ent_op[ready_idx];
                _alu_vj         <= ent_vj[ready_idx];
                _alu_vk         <= ent_vk[ready_idx];
            end
            // The free slot is non-busy, so it never collides with the dispatched one.
            if (issue_ok) begin
                busy[free_idx] <= 1'b1;
            end
        end
    end

    // NOTE: entry payload is deliberately not reset; it is only ever read
    // through a set busy bit, and busy itself is reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in && !_clear) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                if (busy[i] && _cdb_ready) begin
                    if (qj_valid[i] && (ent_qj[i] == _cdb_rob_id)) begin
                        qj_valid[i] <= 1'b0;
                        ent_vj[i]   <= _cdb_value;
                    end
                    if (qk_valid[i] && (ent_qk[i] == _cdb_rob_id)) begin
                        qk_valid[i] <= 1'b0;
                        ent_vk[i]   <= _cdb_value;
                    end
                end
            end
            if (issue_ok) begin
                ent_op[free_idx]   <= _issue_op;
                ent_rob[free_idx]  <= _issue_rob_id;
                ent_qj[free_idx]   <= _issue_qj;
                ent_qk[free_idx]   <= _issue_qk;
                qj_valid[free_idx] <= _issue_qj_valid && !fwd_j;
                qk_valid[free_idx] <= _issue_qk_valid && !fwd_k;
                ent_vj[free_idx]   <= fwd_j ? _cdb_value : _issue_vj;
                ent_vk[free_idx]   <= fwd_k ? _cdb_value : _issue_vk;
            end
        end
    end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a slot-level model.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        _clear;
    logic        _issue_valid;
    logic [4:0]  _issue_rob_id;
    logic [4:0]  _issue_op;
    logic        _issue_qj_valid;
    logic [4:0]  _issue_qj;
    logic [31:0] _issue_vj;
    logic        _issue_qk_valid;
    logic [4:0]  _issue_qk;
    logic [31:0] _issue_vk;
    logic        _rs_full;
    logic        _cdb_ready;
    logic [4:0]  _cdb_rob_id;
    logic [31:0] _cdb_value;
    logic        _alu_full;
    logic        _alu_ready;
    logic [4:0]  _alu_rob_id;
    logic [4:0]  _alu_op;
    logic [31:0] _alu_vj;
    logic [31:0] _alu_vk;

    alu_reservation_station #(.RS_SIZE(8), .ROB_W(5), .OP_W(5)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .rdy_in          (rdy_in),
        ._clear          (_clear),
        ._issue_valid    (_issue_valid),
        ._issue_rob_id   (_issue_rob_id),
        ._issue_op       (_issue_op),
        ._issue_qj_valid (_issue_qj_valid),
        ._issue_qj       (_issue_qj),
        ._issue_vj       (_issue_vj),
        ._issue_qk_valid (_issue_qk_valid),
        ._issue_qk       (_issue_qk),
        ._issue_vk       (_issue_vk),
        ._rs_full        (_rs_full),
        ._cdb_ready      (_cdb_ready),
        ._cdb_rob_id     (_cdb_rob_id),
        ._cdb_value      (_cdb_value),
        ._alu_full       (_alu_full),
        ._alu_ready      (_alu_ready),
        ._alu_rob_id     (_alu_rob_id),
        ._alu_op         (_alu_op),
        ._alu_vj         (_alu_vj),
        ._alu_vk         (_alu_vk)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;
    int proto_cnt = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit          busy;
        logic [4:0]  op;
        logic [4:0]  rob;
        bit          qjv;
        logic [4:0]  qj;
        logic [31:0] vj;
        bit          qkv;
        logic [4:0]  qk;
        logic [31:0] vk;
    } ment_t;

    ment_t       m  [8];
    ment_t       nm [8];
    logic        m_ready;
    logic [4:0]  m_rob;
    logic [4:0]  m_op;
    logic [31:0] m_vj;
    logic [31:0] m_vk;
    logic        n_ready;
    logic [4:0]  n_rob;
    logic [4:0]  n_op;
    logic [31:0] n_vj;
    logic [31:0] n_vk;
    int          pick;
    int          free;
    bit          full;

    function automatic bit model_full();
        bit f = 1'b1;
        for (int i = 0; i < 8; i++) if (!m[i].busy) f = 1'b0;
        return f;
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < 8; i++) m[i].busy <= 1'b0;
            m_ready <= 1'b0;
            m_rob   <= '0;
            m_op    <= '0;
            m_vj    <= '0;
            m_vk    <= '0;
        end else begin
            nm      = m;
            n_ready = 1'b0;
            n_rob   = m_rob;
            n_op    = m_op;
            n_vj    = m_vj;
            n_vk    = m_vk;
            if (_clear) begin
                for (int i = 0; i < 8; i++) nm[i].busy = 1'b0;
            end else if (rdy_in) begin
                pick = -1;
                free = -1;
                full = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    if (m[i].busy && !m[i].qjv && !m[i].qkv && pick < 0) pick = i;
                    if (!m[i].busy && free < 0) free = i;
                    if (!m[i].busy) full = 1'b0;
                end
                for (int i = 0; i < 8; i++) begin
                    if (m[i].busy && _cdb_ready && m[i].qjv && m[i].qj == _cdb_rob_id) begin
                        nm[i].qjv = 1'b0;
                        nm[i].vj  = _cdb_value;
                    end
                    if (m[i].busy && _cdb_ready && m[i].qkv && m[i].qk == _cdb_rob_id) begin
                        nm[i].qkv = 1'b0;
                        nm[i].vk  = _cdb_value;
                    end
                end
                if (!_alu_full && pick >= 0) begin
                    n_ready = 1'b1;
                    n_rob   = m[pick].rob;
                    n_op    = m[pick].op;
                    n_vj    = m[pick].vj;
                    n_vk    = m[pick].vk;
                    nm[pick].busy = 1'b0;
                end
                if (_issue_valid) begin
                    if (full) begin
                        proto_cnt++;
                        $display("protocol: issue while station full at %0t, instruction dropped", $time);
                    end else begin
                        nm[free].busy = 1'b1;
                        nm[free].op   = _issue_op;
                        nm[free].rob  = _issue_rob_id;
                        nm[free].qj   = _issue_qj;
                        nm[free].qk   = _issue_qk;
                        nm[free].qjv  = _issue_qj_valid && !(_cdb_ready && _issue_qj == _cdb_rob_id);
                        nm[free].qkv  = _issue_qk_valid && !(_cdb_ready && _issue_qk == _cdb_rob_id);
                        nm[free].vj   = (_issue_qj_valid && _cdb_ready && _issue_qj == _cdb_rob_id) ? _cdb_value : _issue_vj;
                        nm[free].vk   = (_issue_qk_valid && _cdb_ready && _issue_qk == _cdb_rob_id) ? _cdb_value : _issue_vk;
                    end
                end
            end
            m       <= nm;
            m_ready <= n_ready;
            m_rob   <= n_rob;
            m_op    <= n_op;
            m_vj    <= n_vj;
            m_vk    <= n_vk;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk_in) begin
        if (cmp_en) begin
            check("cyc_alu_ready", 64'(_alu_ready), 64'(m_ready));
            check("cyc_rs_full", 64'(_rs_full), 64'(model_full()));
            check("cyc_alu_rob_id", 64'(_alu_rob_id), 64'(m_rob));
            check("cyc_alu_op", 64'(_alu_op), 64'(m_op));
            check("cyc_alu_vj", 64'(_alu_vj), 64'(m_vj));
            check("cyc_alu_vk", 64'(_alu_vk), 64'(m_vk));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic drive_issue(input logic [4:0] rob, input logic [4:0] op,
                               input logic qjv, input logic [4:0] qj, input logic [31:0] vj,
                               input logic qkv, input logic [4:0] qk, input logic [31:0] vk);
        _issue_valid    = 1'b1;
        _issue_rob_id   = rob;
        _issue_op       = op;
        _issue_qj_valid = qjv;
        _issue_qj       = qj;
        _issue_vj       = vj;
        _issue_qk_valid = qkv;
        _issue_qk       = qk;
        _issue_vk       = vk;
    endtask

    task automatic drive_cdb(input logic rdy, input logic [4:0] rob, input logic [31:0] val);
        _cdb_ready  = rdy;
        _cdb_rob_id = rob;
        _cdb_value  = val;
    endtask

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        _clear = 1'b0;
        _alu_full = 1'b0;
        _issue_valid = 1'b0;
        drive_issue(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        _issue_valid = 1'b0;
        drive_cdb(1'b0, 5'd0, 32'd0);
        repeat (3) @(negedge clk_in);

        check("reset_alu_ready", 64'(_alu_ready), 64'd0);
        check("reset_rs_full", 64'(_rs_full), 64'd0);
        check("reset_alu_rob_id", 64'(_alu_rob_id), 64'd0);
        check("reset_alu_vj", 64'(_alu_vj), 64'd0);
        check("reset_alu_vk", 64'(_alu_vk), 64'd0);
        rst_in = 1'b0;
        cmp_en = 1'b1;
        tick();

        // Ready-at-issue instruction dispatches one edge after the issue edge.
        drive_issue(5'd3, ALU_ADD, 1'b0, 5'd0, 32'd5, 1'b0, 5'd0, 32'd7);
        tick();
        _issue_valid = 1'b0;
        check("s1_not_yet", 64'(_alu_ready), 64'd0);
        tick();
        check("s1_ready", 64'(_alu_ready), 64'd1);
        check("s1_rob", 64'(_alu_rob_id), 64'd3);
        check("s1_vj", 64'(_alu_vj), 64'd5);
        check("s1_vk", 64'(_alu_vk), 64'd7);
        tick();
        check("s1_pulse_end", 64'(_alu_ready), 64'd0);

        // Pending j resolved by a later CDB broadcast.
        drive_issue(5'd4, ALU_SUB, 1'b1, 5'd2, 32'd0, 1'b0, 5'd0, 32'd1);
        tick();
        _issue_valid = 1'b0;
        tick();
        tick();
        drive_cdb(1'b1, 5'd2, 32'h10);
        tick();
        drive_cdb(1'b0, 5'd0, 32'd0);
        check("s2_not_before_capture", 64'(_alu_ready), 64'd0);
        tick();
        check("s2_ready", 64'(_alu_ready), 64'd1);
        check("s2_rob", 64'(_alu_rob_id), 64'd4);
        check("s2_vj", 64'(_alu_vj), 64'h10);

        // Issue-time forwarding from a same-cycle broadcast.
        drive_issue(5'd5, ALU_XOR, 1'b1, 5'd6, 32'd0, 1'b0, 5'd0, 32'd2);
        drive_cdb(1'b1, 5'd6, 32'd9);
        tick();
        _issue_valid = 1'b0;
        drive_cdb(1'b0, 5'd0, 32'd0);
        tick();
        check("s3_ready", 64'(_alu_ready), 64'd1);
        check("s3_rob", 64'(_alu_rob_id), 64'd5);
        check("s3_vj", 64'(_alu_vj), 64'd9);

        // Fill under back-pressure, overflow drop, then drain in slot order.
        _alu_full = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_issue(5'(8 + i), ALU_OR, 1'b0, 5'd0, 32'(100 + i), 1'b0, 5'd0, 32'(i));
            tick();
        end
        check("s4_full", 64'(_rs_full), 64'd1);
        drive_issue(5'd20, ALU_AND, 1'b0, 5'd0, 32'd999, 1'b0, 5'd0, 32'd0);
        tick();
        _issue_valid = 1'b0;
        check("s4_still_full", 64'(_rs_full), 64'd1);
        check("s4_overflow_flagged", 64'(proto_cnt), 64'd1);
        _alu_full = 1'b0;
        tick();
        check("s4_full_drops", 64'(_rs_full), 64'd0);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) tick();
            check("s4_drain_ready", 64'(_alu_ready), 64'd1);
            check("s4_drain_rob", 64'(_alu_rob_id), 64'(8 + i));
            check("s4_drain_vj", 64'(_alu_vj), 64'(100 + i));
        end
        tick();
        check("s4_drain_done", 64'(_alu_ready), 64'd0);

        // Clear wins over a simultaneous issue.
        _alu_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_issue(5'(i), ALU_ADD, 1'b0, 5'd0, 32'd1, 1'b0, 5'd0, 32'd1);
            tick();
        end
        drive_issue(5'd25, ALU_ADD, 1'b0, 5'd0, 32'd3, 1'b0, 5'd0, 32'd3);
        _clear = 1'b1;
        tick();
        _clear = 1'b0;
        _issue_valid = 1'b0;
        _alu_full = 1'b0;
        check("s5_ready_low", 64'(_alu_ready), 64'd0);
        check("s5_not_full", 64'(_rs_full), 64'd0);
        tick();
        check("s5_nothing_stored", 64'(_alu_ready), 64'd0);

        // rdy_in low freezes dispatch and capture.
        _alu_full = 1'b1;
        drive_issue(5'd9, ALU_SLL, 1'b0, 5'd0, 32'd4, 1'b0, 5'd0, 32'd8);
        tick();
        drive_issue(5'd10, ALU_SRL, 1'b0, 5'd0, 32'd6, 1'b1, 5'd11, 32'd0);
        tick();
        _issue_valid = 1'b0;
        _alu_full = 1'b0;
        rdy_in = 1'b0;
        drive_cdb(1'b1, 5'd11, 32'h55);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s6_frozen", 64'(_alu_ready), 64'd0);
        end
        rdy_in = 1'b1;
        drive_cdb(1'b0, 5'd0, 32'd0);
        tick();
        check("s6_one_dispatch", 64'(_alu_ready), 64'd1);
        check("s6_rob", 64'(_alu_rob_id), 64'd9);
        tick();
        check("s6_no_capture_while_frozen", 64'(_alu_ready), 64'd0);
        drive_cdb(1'b1, 5'd11, 32'h66);
        tick();
        drive_cdb(1'b0, 5'd0, 32'd0);
        tick();
        check("s6_late_ready", 64'(_alu_ready), 64'd1);
        check("s6_late_rob", 64'(_alu_rob_id), 64'd10);
        check("s6_late_vk", 64'(_alu_vk), 64'h66);

        // Randomized traffic; the model check runs every cycle.
        for (int c = 0; c < 3000; c++) begin
            rdy_in    = ($urandom_range(0, 99) < 90);
            _clear    = ($urandom_range(0, 99) < 2);
            _alu_full = ($urandom_range(0, 99) < 30);
            drive_issue(5'($urandom_range(0, 31)), 5'($urandom_range(0, 11)),
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                        1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            _issue_valid = ($urandom_range(0, 99) < 60) && !model_full();
            drive_cdb(($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom);
            tick();
        end
        _issue_valid = 1'b0;
        _clear = 1'b0;
        rdy_in = 1'b1;
        drive_cdb(1'b0, 5'd0, 32'd0);
        tick();
        check("final_overflow_count", 64'(proto_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
